// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the barrel-shifter issue/writeback controller.
//   SA_W     : width of a shift amount (5 bits, covers 0..31)
//   SH_SLL / SH_SRL / SH_SRA : shifter op encodings {sign_ext, dir}
//   state_t  : controller FSM states
//   normOp() : folds the unused encoding 2'b10 onto SLL
// ---------------------------------------------------------------------------
package shift_pkg;

    localparam int SA_W = 5;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Sign-extend without a direction bit is meaningless, so 2'b10 is
    // handed to the shifter as a plain left shift.
    function automatic logic [1:0] normOp(input logic [1:0] op);
        return (op == 2'b10) ? SH_SLL : op;
    endfunction

endpackage

// File: rtl/shift_issue_ctrl.sv
// ---------------------------------------------------------------------------
// shift_issue_ctrl
// Issue and writeback controller for the two-stage pipelined barrel shifter.
// Accepts one decoded shift per handshake, registers the shifter operands,
// waits out the shifter's internal register stage, captures the result and
// holds it for the register-file writeback port until it is consumed.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   upstream handshake
//   in_op                 {sign_ext, dir}: 00 SLL, 01 SRL, 11 SRA, 10 -> SLL
//   in_var                1: amount from in_rs[4:0], 0: from in_shamt
//   in_shamt, in_rs       amount sources
//   in_rt                 value to shift
//   in_dst                destination register index
//   flush                 kills the in-flight op
//   sh_opB, sh_sa, sh_op  registered operands to the shifter
//   sh_result             shifter result (valid during WAIT)
//   out_valid / out_ready writeback handshake
//   out_result, out_dst   captured result and destination
//   busy                  controller not idle
//
// Optional feature macro: SHIFT_ZERO_BYPASS_EN
//   When defined, an op whose selected amount is zero skips the shifter and
//   its value is presented for writeback on the cycle after acceptance.
// ---------------------------------------------------------------------------
module shift_issue_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_var,
    input  logic [SA_W-1:0]  in_shamt,
    input  logic [WIDTH-1:0] in_rs,
    input  logic [WIDTH-1:0] in_rt,
    input  logic [4:0]       in_dst,
    input  logic             flush,
    output logic [WIDTH-1:0] sh_opB,
    output logic [SA_W-1:0]  sh_sa,
    output logic [1:0]       sh_op,
    input  logic [WIDTH-1:0] sh_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [4:0]       out_dst,
    output logic             busy
);

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_opB;
    logic [SA_W-1:0]  r_sa;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_result;
    logic [4:0]       r_dst;

    logic             w_inReady;
    logic             w_accept;
    logic [SA_W-1:0]  w_selSa;
    logic             w_zeroBypass;
    logic             w_unusedRs;

    // Only the low bits of the register source form an amount.
    assign w_unusedRs = ^in_rs[WIDTH-1:SA_W];

    assign w_selSa = in_var ? in_rs[SA_W-1:0] : in_shamt;

`ifdef SHIFT_ZERO_BYPASS_EN
    assign w_zeroBypass = (w_selSa == '0);
`else
    assign w_zeroBypass = 1'b0;
`endif

    // A new op can enter when idle, or when the held result leaves this
    // same cycle; flush blocks acceptance outright.
    assign w_inReady = ((r_state == ST_IDLE) ||
                        ((r_state == ST_DONE) && out_ready)) && !flush;
    assign w_accept  = in_valid && w_inReady;

    // Next-state logic; flush overrides everything and returns to IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept)
                    w_nextState = w_zeroBypass ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: w_nextState = ST_WAIT;
            ST_WAIT:  w_nextState = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    if (w_accept)
                        w_nextState = w_zeroBypass ? ST_DONE : ST_ISSUE;
                    else
                        w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
        if (flush)
            w_nextState = ST_IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_nextState;
    end

    // Operand and result registers. Shifter operands change only on an
    // accept edge that actually issues; the result is captured at the end
    // of WAIT unless the op is being killed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_opB    <= '0;
            r_sa     <= '0;
            r_op     <= SH_SLL;
            r_result <= '0;
            r_dst    <= '0;
        end else begin
            if (w_accept) begin
                r_dst <= in_dst;
                if (w_zeroBypass) begin
                    r_result <= in_rt;
                end else begin
                    r_opB <= in_rt;
                    r_sa  <= w_selSa;
                    r_op  <= normOp(in_op);
                end
            end
            if ((r_state == ST_WAIT) && !flush)
                r_result <= sh_result;
        end
    end

    assign in_ready   = w_inReady;
    assign sh_opB     = r_opB;
    assign sh_sa      = r_sa;
    assign sh_op      = r_op;
    assign out_valid  = (r_state == ST_DONE);
    assign out_result = r_result;
    assign out_dst    = r_dst;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_shift_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_issue_ctrl
// Directed self-checking bench for shift_issue_ctrl. A behavioural shifter
// drives sh_result from the registered shifter operands.
// ---------------------------------------------------------------------------
module tb_shift_issue_ctrl;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic             in_var;
    logic [4:0]       in_shamt;
    logic [WIDTH-1:0] in_rs;
    logic [WIDTH-1:0] in_rt;
    logic [4:0]       in_dst;
    logic             flush;
    logic [WIDTH-1:0] sh_opB;
    logic [4:0]       sh_sa;
    logic [1:0]       sh_op;
    logic [WIDTH-1:0] sh_result;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [4:0]       out_dst;
    logic             busy;

    int total = 0;
    int bad   = 0;

    shift_issue_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_var(in_var), .in_shamt(in_shamt),
        .in_rs(in_rs), .in_rt(in_rt), .in_dst(in_dst),
        .flush(flush),
        .sh_opB(sh_opB), .sh_sa(sh_sa), .sh_op(sh_op),
        .sh_result(sh_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_dst(out_dst),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural shifter: result is a function of the registered operands.
    always_comb begin
        case (sh_op)
            2'b01:   sh_result = sh_opB >> sh_sa;
            2'b11:   sh_result = $signed(sh_opB) >>> sh_sa;
            default: sh_result = sh_opB << sh_sa;
        endcase
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] op, input logic v, input logic [4:0] sa,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] dst);
        in_valid = 1'b1;
        in_op    = op;
        in_var   = v;
        in_shamt = sa;
        in_rs    = rs;
        in_rt    = rt;
        in_dst   = dst;
        #1;
    endtask

    // Samples once per cycle from the first post-accept cycle; lat = 1 means
    // out_valid was seen in cycle t+1, -1 means it never came.
    task automatic waitValid(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            if (out_valid === 1'b1) begin
                lat = i;
                break;
            end
            cycle();
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        total++; if (out_result !== 32'h0) begin bad++; $display("[TB] FAIL reset_out_result got=%h exp=0", out_result); end
        total++; if (out_dst !== 5'd0) begin bad++; $display("[TB] FAIL reset_out_dst got=%0d exp=0", out_dst); end
        total++; if (sh_opB !== 32'h0) begin bad++; $display("[TB] FAIL reset_sh_opB got=%h exp=0", sh_opB); end
        total++; if (sh_sa !== 5'd0) begin bad++; $display("[TB] FAIL reset_sh_sa got=%0d exp=0", sh_sa); end
        total++; if (sh_op !== 2'b00) begin bad++; $display("[TB] FAIL reset_sh_op got=%b exp=00", sh_op); end
    endtask

    task automatic test_sll();
        int lat;
        offer(2'b00, 1'b0, 5'd4, 32'h0, 32'h0000_0001, 5'd7);
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL sll_in_ready got=%b exp=1", in_ready); end
        cycle();
        in_valid = 1'b0;
        total++; if (sh_sa !== 5'd4) begin bad++; $display("[TB] FAIL sll_sh_sa got=%0d exp=4", sh_sa); end
        total++; if (sh_opB !== 32'h1) begin bad++; $display("[TB] FAIL sll_sh_opB got=%h exp=1", sh_opB); end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL sll_busy got=%b exp=1", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL sll_in_ready_busy got=%b exp=0", in_ready); end
        waitValid(lat);
        total++; if (lat !== 3) begin bad++; $display("[TB] FAIL sll_latency got=%0d exp=3", lat); end
        total++; if (out_result !== 32'h0000_0010) begin bad++; $display("[TB] FAIL sll_result got=%h exp=00000010", out_result); end
        total++; if (out_dst !== 5'd7) begin bad++; $display("[TB] FAIL sll_dst got=%0d exp=7", out_dst); end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL sll_done_in_ready got=%b exp=1", in_ready); end
        cycle();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL sll_consumed_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL sll_consumed_busy got=%b exp=0", busy); end
    endtask

    task automatic test_right_shifts();
        int lat;
        offer(2'b11, 1'b0, 5'd31, 32'h0, 32'h8000_0000, 5'd2);
        cycle();
        in_valid = 1'b0;
        total++; if (sh_op !== 2'b11) begin bad++; $display("[TB] FAIL sra_sh_op got=%b exp=11", sh_op); end
        waitValid(lat);
        total++; if (lat !== 3) begin bad++; $display("[TB] FAIL sra_latency got=%0d exp=3", lat); end
        total++; if (out_result !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL sra_result got=%h exp=ffffffff", out_result); end
        consume();

        offer(2'b01, 1'b0, 5'd31, 32'h0, 32'h8000_0000, 5'd3);
        cycle();
        in_valid = 1'b0;
        total++; if (sh_op !== 2'b01) begin bad++; $display("[TB] FAIL srl_sh_op got=%b exp=01", sh_op); end
        waitValid(lat);
        total++; if (out_result !== 32'h0000_0001) begin bad++; $display("[TB] FAIL srl_result got=%h exp=00000001", out_result); end
        total++; if (out_dst !== 5'd3) begin bad++; $display("[TB] FAIL srl_dst got=%0d exp=3", out_dst); end
        consume();

        offer(2'b10, 1'b0, 5'd1, 32'h0, 32'h0000_0003, 5'd4);
        cycle();
        in_valid = 1'b0;
        total++; if (sh_op !== 2'b00) begin bad++; $display("[TB] FAIL op10_sh_op got=%b exp=00", sh_op); end
        waitValid(lat);
        total++; if (out_result !== 32'h0000_0006) begin bad++; $display("[TB] FAIL op10_result got=%h exp=00000006", out_result); end
        consume();
    endtask

    task automatic test_variable();
        int lat;
        offer(2'b01, 1'b1, 5'd5, 32'h0000_0023, 32'h0000_00F0, 5'd9);
        cycle();
        in_valid = 1'b0;
        total++; if (sh_sa !== 5'd3) begin bad++; $display("[TB] FAIL srlv_sh_sa got=%0d exp=3", sh_sa); end
        waitValid(lat);
        total++; if (lat !== 3) begin bad++; $display("[TB] FAIL srlv_latency got=%0d exp=3", lat); end
        total++; if (out_result !== 32'h0000_001E) begin bad++; $display("[TB] FAIL srlv_result got=%h exp=0000001e", out_result); end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        offer(2'b00, 1'b0, 5'd1, 32'h0, 32'h0000_000A, 5'd3);
        cycle();
        waitValid(lat);
        total++; if (lat !== 3) begin bad++; $display("[TB] FAIL bp_latency got=%0d exp=3", lat); end
        // Offer the next op while writeback stalls.
        offer(2'b00, 1'b0, 5'd2, 32'h0, 32'h0000_0006, 5'd9);
        for (int i = 0; i < 5; i++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, out_valid); end
            total++; if (out_result !== 32'h0000_0014) begin bad++; $display("[TB] FAIL bp_hold_result cyc=%0d got=%h exp=00000014", i, out_result); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_hold_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
            cycle();
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_in_ready got=%b exp=1", in_ready); end
        cycle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_busy got=%b exp=1", busy); end
        total++; if (sh_opB !== 32'h6 || sh_sa !== 5'd2) begin bad++; $display("[TB] FAIL b2b_operands got=%h/%0d exp=00000006/2", sh_opB, sh_sa); end
        waitValid(lat);
        total++; if (lat !== 3) begin bad++; $display("[TB] FAIL b2b_latency got=%0d exp=3", lat); end
        total++; if (out_result !== 32'h0000_0018) begin bad++; $display("[TB] FAIL b2b_result got=%h exp=00000018", out_result); end
        total++; if (out_dst !== 5'd9) begin bad++; $display("[TB] FAIL b2b_dst got=%0d exp=9", out_dst); end
        consume();
    endtask

    task automatic test_flush();
        int lat;
        int seen;
        offer(2'b00, 1'b0, 5'd1, 32'h0, 32'h0000_0001, 5'd4);
        cycle();
        cycle();
        // Now in WAIT: flush together with a fresh offer.
        offer(2'b00, 1'b0, 5'd3, 32'h0, 32'h0000_0077, 5'd8);
        flush = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_in_ready got=%b exp=0", in_ready); end
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL flush_busy got=%b exp=0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_in_ready_after got=%b exp=1", in_ready); end
        total++; if (sh_opB !== 32'h1) begin bad++; $display("[TB] FAIL flush_no_accept got=%h exp=00000001", sh_opB); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid !== 1'b0) seen++;
            cycle();
        end
        total++; if (seen !== 0) begin bad++; $display("[TB] FAIL flush_no_result got=%0d exp=0", seen); end

        // Flush while a result is held.
        offer(2'b00, 1'b0, 5'd2, 32'h0, 32'h0000_0001, 5'd6);
        cycle();
        in_valid = 1'b0;
        waitValid(lat);
        total++; if (out_result !== 32'h0000_0004) begin bad++; $display("[TB] FAIL flush_done_result got=%h exp=00000004", out_result); end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_done_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        offer(2'b01, 1'b0, 5'd2, 32'h0, 32'h0000_00FF, 5'd5);
        cycle();
        in_valid = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy got=%b exp=0", busy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_valid got=%b exp=0", out_valid); end
        total++; if (out_result !== 32'h0) begin bad++; $display("[TB] FAIL rstmid_result got=%h exp=0", out_result); end
        total++; if (out_dst !== 5'd0) begin bad++; $display("[TB] FAIL rstmid_dst got=%0d exp=0", out_dst); end
        total++; if (sh_opB !== 32'h0 || sh_sa !== 5'd0 || sh_op !== 2'b00) begin bad++; $display("[TB] FAIL rstmid_sh got=%h/%0d/%b exp=0/0/00", sh_opB, sh_sa, sh_op); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        cycle();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_no_result got=%b exp=0", out_valid); end
    endtask

    task automatic test_zero_amount();
        int lat;
        int expLat;
        logic [31:0] expOpB;
`ifdef SHIFT_ZERO_BYPASS_EN
        expLat = 1;
        expOpB = 32'h0;
`else
        expLat = 3;
        expOpB = 32'h1234_5678;
`endif
        offer(2'b00, 1'b0, 5'd0, 32'h0, 32'h1234_5678, 5'd1);
        cycle();
        in_valid = 1'b0;
        total++; if (sh_opB !== expOpB) begin bad++; $display("[TB] FAIL zero_sh_opB got=%h exp=%h", sh_opB, expOpB); end
        waitValid(lat);
        total++; if (lat !== expLat) begin bad++; $display("[TB] FAIL zero_latency got=%0d exp=%0d", lat, expLat); end
        total++; if (out_result !== 32'h1234_5678) begin bad++; $display("[TB] FAIL zero_result got=%h exp=12345678", out_result); end
        total++; if (out_dst !== 5'd1) begin bad++; $display("[TB] FAIL zero_dst got=%0d exp=1", out_dst); end
        consume();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_var    = 1'b0;
        in_shamt  = '0;
        in_rs     = '0;
        in_rt     = '0;
        in_dst    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #2;
        test_reset();
        test_sll();
        test_right_shifts();
        test_variable();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_zero_amount();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
